// File: rtl/vga_pkg.sv
// vga_pkg: movementData field layout, sprite motion FSM encoding, default
// offset range and the offset bounding helper.
// Build option: define SPRITE_MOTION_WRAP_EN to make offsets wrap around
// instead of saturating at the range limits.
package vga_pkg;

  // movementData layout; X and Y share bit 4, which carries y_off[4]
  localparam int MD_W       = 15;
  localparam int X_LSB      = 4;
  localparam int X_W        = 6;
  localparam int Y_LSB      = 0;
  localparam int Y_W        = 5;
  localparam int MOVING_BIT = 12;

  // default sprite offset range (minimum is always 0)
  localparam int DEF_X_MAX = 63;
  localparam int DEF_Y_MAX = 31;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRESS  = 2'd1,
    HOLD   = 2'd2,
    REPEAT = 2'd3
  } motion_state_t;

  // offsets are moved in 8-bit signed arithmetic so underflow is visible
  typedef logic signed [7:0] off_calc_t;

  // bring a candidate offset back into [0, max_val]
  function automatic off_calc_t bound_offset(input off_calc_t value,
                                             input off_calc_t max_val);
    off_calc_t result;
`ifdef SPRITE_MOTION_WRAP_EN
    if (value < 0)
      result = value + max_val + 8'sd1;
    else if (value > max_val)
      result = value - max_val - 8'sd1;
    else
      result = value;
`else
    if (value < 0)
      result = '0;
    else if (value > max_val)
      result = max_val;
    else
      result = value;
`endif
    return result;
  endfunction

  // assemble the movementData word from its fields
  function automatic logic [MD_W-1:0] pack_movement(input logic           moving,
                                                    input logic [X_W-1:0] x_off,
                                                    input logic [Y_W-1:0] y_off);
    logic [MD_W-1:0] word;
    word                = '0;
    word[MOVING_BIT]    = moving;
    word[X_LSB +: X_W]  = x_off;
    // Y is written last so the shared bit 4 is owned by y_off[4]
    word[Y_LSB +: Y_W]  = y_off;
    return word;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser followed by a stability counter for
// one raw pushbutton. The debounced level only changes after the
// synchronised input has disagreed with it for DEBOUNCE_CYCLES cycles in a row.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic srst,
  input  logic btn_raw,
  output logic btn_db
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_reg;
  logic             sync_reg;
  logic             db_reg;
  logic             db_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // two-flop synchroniser for the asynchronous button input
  always_ff @(posedge clk) begin
    if (srst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= btn_raw;
      sync_reg <= meta_reg;
    end
  end

  // count disagreement cycles; any agreement restarts the count
  always_comb begin
    cnt_next = '0;
    db_next  = db_reg;
    if (sync_reg != db_reg) begin
      if (cnt_reg == CNT_LAST)
        db_next = ~db_reg;
      else
        cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  // debounced level and stability counter
  always_ff @(posedge clk) begin
    if (srst) begin
      db_reg  <= 1'b0;
      cnt_reg <= '0;
    end else begin
      db_reg  <= db_next;
      cnt_reg <= cnt_next;
    end
  end

  assign btn_db = db_reg;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: turns four direction buttons into a per-frame X/Y
// sprite offset with press-then-auto-repeat behaviour. Position and the
// movementData word only change in the cycle after a frame tick, so the
// sprite never tears mid-frame.
// Build option: SPRITE_MOTION_WRAP_EN selects wrap-around offsets instead
// of saturating ones (see vga_pkg::bound_offset).
module sprite_motion_ctrl
  import vga_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int STEP            = 1,
  parameter int X_MAX           = DEF_X_MAX,
  parameter int Y_MAX           = DEF_Y_MAX,
  parameter int HOLD_FRAMES     = 20
) (
  input  logic            CLK100MHZ,
  input  logic            reset,
  input  logic            btn_up,
  input  logic            btn_down,
  input  logic            btn_left,
  input  logic            btn_right,
  input  logic            vga_vs,
  output logic [MD_W-1:0] movementData,
  output logic            frame_tick
);

  localparam off_calc_t STEP8  = off_calc_t'(STEP);
  localparam off_calc_t X_MAX8 = off_calc_t'(X_MAX);
  localparam off_calc_t Y_MAX8 = off_calc_t'(Y_MAX);

  localparam int                HOLD_W    = $clog2(HOLD_FRAMES) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

  // button bit order: [0]=right [1]=left [2]=down [3]=up
  logic [3:0] btn_raw;
  logic [3:0] btn_db;

  logic vs_meta_reg;
  logic vs_sync_reg;
  logic vs_prev_reg;
  logic frame_tick_reg;

  logic signed [1:0] dx;
  logic signed [1:0] dy;
  logic              any_dir;
  off_calc_t         x_step;
  off_calc_t         y_step;
  off_calc_t         x_sum;
  off_calc_t         y_sum;
  logic [X_W-1:0]    x_move;
  logic [Y_W-1:0]    y_move;
  logic [X_W-1:0]    x_upd;
  logic [Y_W-1:0]    y_upd;

  motion_state_t     state_reg;
  motion_state_t     state_next;
  logic              moving_next;
  logic              apply_move;
  logic              hold_clr;
  logic              hold_inc;

  logic [X_W-1:0]    x_off_reg;
  logic [Y_W-1:0]    y_off_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic [MD_W-1:0]   movement_reg;

  assign btn_raw = {btn_up, btn_down, btn_left, btn_right};

  // one synchroniser + debouncer per direction button
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk    (CLK100MHZ),
        .srst   (reset),
        .btn_raw(btn_raw[gi]),
        .btn_db (btn_db[gi])
      );
    end
  endgenerate

  // synchronise VS (idle high) and register a one-cycle pulse on its falling edge
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      vs_meta_reg    <= 1'b1;
      vs_sync_reg    <= 1'b1;
      vs_prev_reg    <= 1'b1;
      frame_tick_reg <= 1'b0;
    end else begin
      vs_meta_reg    <= vga_vs;
      vs_sync_reg    <= vs_meta_reg;
      vs_prev_reg    <= vs_sync_reg;
      frame_tick_reg <= vs_prev_reg & ~vs_sync_reg;
    end
  end

  // resolve buttons into per-axis directions; opposing buttons cancel
  always_comb begin
    dx = 2'sb00;
    dy = 2'sb00;
    case ({btn_db[0], btn_db[1]})
      2'b10:   dx = 2'sb01;
      2'b01:   dx = 2'sb11;
      default: dx = 2'sb00;
    endcase
    case ({btn_db[2], btn_db[3]})
      2'b10:   dy = 2'sb01;
      2'b01:   dy = 2'sb11;
      default: dy = 2'sb00;
    endcase
    any_dir = (dx != 2'sb00) || (dy != 2'sb00);
  end

  // candidate offsets after one move, bounded to the legal range
  always_comb begin
    x_step = '0;
    y_step = '0;
    if (dx == 2'sb01)
      x_step = STEP8;
    else if (dx == 2'sb11)
      x_step = -STEP8;
    if (dy == 2'sb01)
      y_step = STEP8;
    else if (dy == 2'sb11)
      y_step = -STEP8;
    x_sum  = off_calc_t'({{(8 - X_W){1'b0}}, x_off_reg}) + x_step;
    y_sum  = off_calc_t'({{(8 - Y_W){1'b0}}, y_off_reg}) + y_step;
    x_move = X_W'(bound_offset(x_sum, X_MAX8));
    y_move = Y_W'(bound_offset(y_sum, Y_MAX8));
    x_upd  = apply_move ? x_move : x_off_reg;
    y_upd  = apply_move ? y_move : y_off_reg;
  end

  // motion FSM state register
  always_ff @(posedge CLK100MHZ) begin
    if (reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // motion FSM next state; releasing every direction always returns to IDLE
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (any_dir)
          state_next = PRESS;
      end
      PRESS: begin
        if (!any_dir)
          state_next = IDLE;
        else if (frame_tick_reg)
          state_next = HOLD;
      end
      HOLD: begin
        if (!any_dir)
          state_next = IDLE;
        else if (frame_tick_reg && (hold_cnt_reg == HOLD_LAST))
          state_next = REPEAT;
      end
      REPEAT: begin
        if (!any_dir)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // motion FSM outputs: when to move and how to drive the hold counter
  always_comb begin
    apply_move  = 1'b0;
    hold_clr    = 1'b0;
    hold_inc    = 1'b0;
    // moving flag is captured alongside the offsets, so take it from the
    // state the FSM enters on this tick
    moving_next = (state_next != IDLE);
    if (frame_tick_reg && any_dir) begin
      case (state_reg)
        PRESS: begin
          apply_move = 1'b1;
          hold_clr   = 1'b1;
        end
        HOLD:    hold_inc   = 1'b1;
        REPEAT:  apply_move = 1'b1;
        default: apply_move = 1'b0;
      endcase
    end
  end

  // offsets, hold counter and output word only advance on a frame tick
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      x_off_reg    <= '0;
      y_off_reg    <= '0;
      hold_cnt_reg <= '0;
      movement_reg <= '0;
    end else begin
      if (frame_tick_reg) begin
        x_off_reg    <= x_upd;
        y_off_reg    <= y_upd;
        movement_reg <= pack_movement(moving_next, x_upd, y_upd);
      end
      if (hold_clr)
        hold_cnt_reg <= '0;
      else if (hold_inc)
        hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
    end
  end

  assign movementData = movement_reg;
  assign frame_tick   = frame_tick_reg;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl: table-driven frame vectors with a scoreboard queue
// of expected movementData words, plus hand-written sequences for reset,
// debounce timing, long auto-repeat into the range limit and reset mid-motion.
module tb_sprite_motion_ctrl;

  localparam int DEB_TB   = 4;
  localparam int HOLD_TB  = 3;
  localparam int Y_MAX_TB = 31;
`ifdef SPRITE_MOTION_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_up, btn_down, btn_left, btn_right;
  logic        vga_vs;
  logic [14:0] movementData;
  logic        frame_tick;

  int n_checks = 0;
  int n_errors = 0;

  logic [14:0] sb_q[$];
  logic [14:0] last_md;

  typedef struct {
    logic [3:0] btn;   // {up, down, left, right}
    logic [5:0] x;
    logic [4:0] y;
    logic       mv;
  } vec_t;

  vec_t vecs[23];

  always #5 clk = ~clk;

  sprite_motion_ctrl #(
    .DEBOUNCE_CYCLES(DEB_TB),
    .STEP           (1),
    .X_MAX          (63),
    .Y_MAX          (Y_MAX_TB),
    .HOLD_FRAMES    (HOLD_TB)
  ) dut (
    .CLK100MHZ   (clk),
    .reset       (reset),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .vga_vs      (vga_vs),
    .movementData(movementData),
    .frame_tick  (frame_tick)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // expected word: bits[9:5]=x[5:1], bit4=y[4], bits[3:0]=y[3:0], bit12=moving
  function automatic logic [14:0] make_md(input logic mv, input logic [5:0] x, input logic [4:0] y);
    return {2'b00, mv, 2'b00, x[5:1], y};
  endfunction

  function automatic vec_t mk(input logic [3:0] b, input int x, input int y, input logic mv);
    vec_t v;
    v.btn = b;
    v.x   = 6'(x);
    v.y   = 5'(y);
    v.mv  = mv;
    return v;
  endfunction

  task automatic set_btn(input logic [3:0] b);
    {btn_up, btn_down, btn_left, btn_right} = b;
    repeat (8) step();
  endtask

  // one VS pulse: check tick latency and width, then the registered word
  task automatic do_frame(input string name, input logic [5:0] ex, input logic [4:0] ey, input logic emv);
    int          n;
    bit          seen;
    logic [14:0] want;
    sb_q.push_back(make_md(emv, ex, ey));
    vga_vs = 1'b0;
    n      = 0;
    seen   = 1'b0;
    while (!seen && n < 10) begin
      step();
      n++;
      if (frame_tick === 1'b1) seen = 1'b1;
    end
    check({name, "_tick_seen"}, 32'(seen), 32'd1);
    check({name, "_tick_lat"}, 32'(n), 32'd3);
    check({name, "_md_stable"}, 32'(movementData), 32'(last_md));
    step();
    want = sb_q.pop_front();
    check({name, "_md"}, 32'(movementData), 32'(want));
    check({name, "_tick_pulse"}, 32'(frame_tick), 32'd0);
    check({name, "_x_off"}, 32'(dut.x_off_reg), 32'(ex));
    $display("frame %s: movementData=%h expected=%h x_off=%0d", name, movementData, want, dut.x_off_reg);
    last_md = want;
    vga_vs  = 1'b1;
    repeat (4) step();
  endtask

  initial begin
    int xl, xa, ex, ey, n;

    xl = WRAP ? 63 : 0;
    xa = (xl + 1) % 64;

    vecs[0]  = mk(4'b0001, 1, 0, 1'b1);       // right: first move
    vecs[1]  = mk(4'b0001, 1, 0, 1'b1);       // right held: HOLD, no move
    vecs[2]  = mk(4'b0000, 1, 0, 1'b0);       // release
    vecs[3]  = mk(4'b0100, 1, 1, 1'b1);       // down: auto-repeat run
    vecs[4]  = mk(4'b0100, 1, 1, 1'b1);
    vecs[5]  = mk(4'b0100, 1, 1, 1'b1);
    vecs[6]  = mk(4'b0100, 1, 1, 1'b1);
    vecs[7]  = mk(4'b0100, 1, 2, 1'b1);
    vecs[8]  = mk(4'b0100, 1, 3, 1'b1);
    vecs[9]  = mk(4'b0100, 1, 4, 1'b1);
    vecs[10] = mk(4'b0100, 1, 5, 1'b1);
    vecs[11] = mk(4'b0000, 1, 5, 1'b0);
    vecs[12] = mk(4'b0010, 0, 5, 1'b1);       // left: 1 -> 0
    vecs[13] = mk(4'b0010, 0, 5, 1'b1);
    vecs[14] = mk(4'b0010, 0, 5, 1'b1);
    vecs[15] = mk(4'b0010, 0, 5, 1'b1);
    vecs[16] = mk(4'b0010, xl, 5, 1'b1);      // left from 0: clamp or wrap
    vecs[17] = mk(4'b0000, xl, 5, 1'b0);
    vecs[18] = mk(4'b1100, xl, 5, 1'b0);      // up+down cancel: stays idle
    vecs[19] = mk(4'b1101, xa, 5, 1'b1);      // up+down+right: only X moves
    vecs[20] = mk(4'b0000, xa, 5, 1'b0);
    vecs[21] = mk(4'b0101, xa + 1, 6, 1'b1);  // diagonal right+down
    vecs[22] = mk(4'b0000, xa + 1, 6, 1'b0);

    // reset with all buttons held
    reset   = 1'b1;
    vga_vs  = 1'b1;
    {btn_up, btn_down, btn_left, btn_right} = 4'b1111;
    last_md = '0;
    repeat (2) step();
    check("rst_md", 32'(movementData), 32'h0);
    check("rst_tick", 32'(frame_tick), 32'd0);
    check("rst_state", 32'(dut.state_reg), 32'(vga_pkg::IDLE));
    check("rst_db", 32'(dut.btn_db), 32'h0);
    reset = 1'b0;
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    repeat (4) step();

    // 3-cycle glitch must not be accepted
    btn_right = 1'b1;
    repeat (3) step();
    btn_right = 1'b0;
    repeat (8) step();
    check("glitch_db", 32'(dut.btn_db), 32'h0);
    check("glitch_state", 32'(dut.state_reg), 32'(vga_pkg::IDLE));

    // held press is accepted after 2 sync + 4 count cycles
    btn_right = 1'b1;
    n = 0;
    while (dut.btn_db[0] !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("db_latency", 32'(n), 32'd6);
    repeat (2) step();
    check("press_state", 32'(dut.state_reg), 32'(vga_pkg::PRESS));

    for (int i = 0; i < 23; i++) begin
      set_btn(vecs[i].btn);
      do_frame($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].mv);
    end

    // long down hold: press move, HOLD_TB hold frames, then repeat into the Y limit
    ex = xa + 1;
    ey = 6;
    set_btn(4'b0100);
    for (int k = 1; k <= 32; k++) begin
      if (k == 1 || k >= HOLD_TB + 2) begin
        if (ey == Y_MAX_TB)
          ey = WRAP ? 0 : Y_MAX_TB;
        else
          ey++;
      end
      do_frame($sformatf("yrun%0d", k), 6'(ex), 5'(ey), 1'b1);
    end
    set_btn(4'b0000);
    do_frame("yrel", 6'(ex), 5'(ey), 1'b0);

    // reset in the middle of a motion abandons it
    set_btn(4'b0001);
    ex = ex + 1;
    do_frame("pre_rst", 6'(ex), 5'(ey), 1'b1);
    reset = 1'b1;
    repeat (2) step();
    check("midrst_md", 32'(movementData), 32'h0);
    check("midrst_state", 32'(dut.state_reg), 32'(vga_pkg::IDLE));
    check("midrst_x", 32'(dut.x_off_reg), 32'd0);
    reset = 1'b0;
    last_md = '0;
    set_btn(4'b0000);
    do_frame("post_rst", 6'd0, 5'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
